event_encoder_4x2: RTL and testbench
====================================

Name: event_encoder_4x2

Overview:
- Sequential 4-to-2 priority encoder. It is the encode-side counterpart of the team's 2x4 decoder.
- Captures single-cycle event pulses on 4 request lines into sticky pending bits.
- Presents the highest-priority pending index as a 2-bit code over a valid/ready handshake.
- Sits between event sources (interrupt/exception lines) and a consumer that handles one event per transfer. A 2x4 decoder driven by out_idx regenerates the one-hot line.

Parameters:
- N, 4, number of request lines; fixed at 4 for this revision.
- W, 2, index width = log2(N).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  event pulses; bit i high for one cycle = one event on line i.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- clr_ovf  input  1  synchronous clear of ovf.
- out_valid  output  1  out_idx/out_onehot hold a valid event.
- out_idx  output  W  encoded index of the presented event.
- out_onehot  output  N  one-hot of out_idx; all zeros when out_valid=0.
- pending  output  N  registered pending bits, excluding the presented event.
- ovf  output  N  sticky: event on line i was coalesced (lost).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Named clk and rst_n.
- Reset (async assert, sync release):
  - out_valid=0, out_idx=0, out_onehot=0, pending=0, ovf=0.
  - Reset mid-transfer discards the held event and all pending bits without handshake.
- Priority: bit 0 is highest. Index 0 wins over 1, 1 over 2, 2 over 3.
- Candidate set per cycle: cand = pending | req.
- load = !out_valid || out_ready.
- On a clock edge with load=1 and cand!=0:
  - out_valid<=1 and out_idx<=lowest set index k of cand.
  - out_onehot<=(1<<k).
  - pending<=(cand & ~(1<<k)).
- On a clock edge with load=1 and cand==0: out_valid<=0, out_onehot<=0, out_idx holds its last value.
- On a clock edge with load=0 (stall): output registers hold, and pending<=pending | req.
- Latency: req[i] pulse in cycle t with an idle output gives out_valid=1, out_idx=i after edge t+1 (1 cycle).
- Throughput: one event per cycle while out_ready=1. Back-to-back transfers need no bubble.
- Coalescing:
  - req[i]=1 while pending[i]=1 sets ovf[i]; the event merges into the existing pending bit.
  - req[i]=1 in the same cycle that index i is loaded into the output clears that pending bit; it does not set ovf.
  - req[i]=1 while out_idx=i is presented but not being reloaded sets pending[i], not ovf.
- ovf clearing:
  - clr_ovf=1 clears ovf on the next edge.
  - If clr_ovf and a new coalesce occur in the same cycle, set wins.
- Handshake rules:
  - out_idx and out_onehot are stable while out_valid && !out_ready.
  - The consumer must not depend on out_idx when out_valid=0.
- Starvation: lower-priority lines may starve under continuous higher-priority traffic. This is by design; no fairness.
- Invariant: out_onehot == (out_valid ? 1<<out_idx : 0) every cycle.

Decomposition:
- Shared package holds:
  - N and W constants.
  - A function lowest_set(vec) returning index and found flag.
  - A function onehot(idx).
- One natural sub-module, prio_enc_4x2: purely combinational priority encoder (vec -> idx, any). It is instantiated once on cand.
- Pending, output, and ovf registers live in the top.

Test Plan:
- Reset with req=4'b1111 held: while rst_n=0, all outputs 0. Release, one pulse of 4'b1111, out_ready=1:
  - Out_idx sequence 0,1,2,3 on consecutive cycles, out_valid=1 for exactly 4 cycles.
  - pending goes 1110, 1100, 1000, 0000.
  - out_onehot goes 0001, 0010, 0100, 1000.
- Stall: pulse req=4'b0100, out_ready=0 for 5 cycles:
  - out_valid=1, out_idx=2 stable.
  - Pulse req=4'b0001 during the stall: pending=0001.
  - Raise out_ready: next cycle out_idx=0, then out_valid=0.
- Coalesce: out_ready=0, pulse req=4'b1000 twice more after it has been presented:
  - First extra pulse gives pending[3]=1, ovf=0.
  - Second extra pulse gives ovf=4'b1000.
  - clr_ovf pulse gives ovf=0 next cycle.
- Same-cycle consume: idle output, req=4'b0010 held 3 cycles, out_ready=1:
  - Out_idx=1 valid for 3 consecutive cycles.
  - ovf stays 0 and pending stays 0.
- Async reset mid-operation: with out_valid=1 and pending=4'b1010, drop rst_n between clock edges:
  - All outputs 0 immediately, with no clock edge needed.
  - After release with req=0, out_valid stays 0.
- Random pulses with random out_ready for 10k cycles, checked against a scoreboard model:
  - Counts of events accepted plus ovf-flagged coalesces match the model.
  - The out_onehot invariant holds on every cycle.

Source files
------------

// File: rtl/event_encoder_4x2_pkg.sv
// rtl/event_encoder_4x2_pkg.sv - shared constants and helpers for the 4x2 event encoder
package event_encoder_4x2_pkg;

    localparam int N = 4;
    localparam int W = 2;

    typedef struct packed {
        logic         found;
        logic [W-1:0] idx;
    } enc_t;

    // Bit 0 is highest priority: scan downward so the lowest set bit wins last.
    function automatic enc_t lowest_set(input logic [N-1:0] vec);
        enc_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/event_encoder_4x2_prio_enc.sv
// rtl/event_encoder_4x2_prio_enc.sv - combinational 4-to-2 priority encoder, index 0 highest
module prio_enc_4x2
    import event_encoder_4x2_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    enc_t enc;

    assign enc = lowest_set(vec);
    assign idx = enc.idx;
    assign any = enc.found;

endmodule

// File: rtl/event_encoder_4x2.sv
// rtl/event_encoder_4x2.sv - sticky event capture with prioritised valid/ready index output
module event_encoder_4x2
    import event_encoder_4x2_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending,
    output logic [N-1:0] ovf
);

    logic [N-1:0] cand;
    logic [N-1:0] win_oh;
    logic [W-1:0] win_idx;
    logic         win_any;
    logic         load;

    assign cand = pending | req;
    assign load = !out_valid || out_ready;

    prio_enc_4x2 u_prio (
        .vec (cand),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_oh = onehot(win_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            pending    <= '0;
            ovf        <= '0;
        end else begin
            // A new event on an already-pending line is lost; setting beats clearing.
            ovf <= (clr_ovf ? '0 : ovf) | (req & pending);
            if (load) begin
                out_valid  <= win_any;
                out_onehot <= win_any ? win_oh : '0;
                if (win_any) begin
                    out_idx <= win_idx;
                end
                pending <= win_any ? (cand & ~win_oh) : cand;
            end else begin
                pending <= cand;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder_4x2.sv
// tb/tb_event_encoder_4x2.sv - table-driven and randomised scoreboard bench for event_encoder_4x2
module tb_event_encoder_4x2;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic [3:0] oh;
        logic [3:0] pend;
        logic [3:0] ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic       clr;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] out_onehot;
    logic [3:0] pending;
    logic [3:0] ovf;

    int   errors = 0;
    int   checks = 0;
    int   injected = 0;
    int   lost = 0;
    int   m_acc = 0;
    int   dut_acc = 0;
    exp_t m = '0;
    exp_t sbq[$];
    vec_t vecs[27];

    event_encoder_4x2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic c,
                                input logic v, input logic [1:0] i, input logic [3:0] oh,
                                input logic [3:0] p, input logic [3:0] o);
        vec_t t;
        t.req = r; t.rdy = rd; t.clr = c;
        t.e.valid = v; t.e.idx = i; t.e.oh = oh; t.e.pend = p; t.e.ovf = o;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, row, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rd, input logic c, output exp_t e);
        logic [3:0] cand;
        int k;
        cand = m.pend | r;
        injected += $countones(r);
        lost += $countones(r & m.pend);
        if (m.valid && rd) m_acc++;
        m.ovf = (c ? 4'b0 : m.ovf) | (r & m.pend);
        if (!m.valid || rd) begin
            k = -1;
            for (int i = 3; i >= 0; i--) if (cand[i]) k = i;
            if (k < 0) begin
                m.valid = 1'b0;
                m.oh = 4'b0;
                m.pend = 4'b0;
            end else begin
                m.valid = 1'b1;
                m.idx = k[1:0];
                m.oh = 4'b0001 << k;
                m.pend = cand;
                m.pend[k] = 1'b0;
            end
        end else begin
            m.pend = cand;
        end
        e = m;
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic step(input logic [3:0] r, input logic rd, input logic c,
                        input logic use_tab, input exp_t tab, input string nm, input int row);
        exp_t me;
        exp_t got;
        req = r; out_ready = rd; clr_ovf = c;
        if (out_valid && rd) dut_acc++;
        model_step(r, rd, c, me);
        sbq.push_back(use_tab ? tab : me);
        @(posedge clk);
        #1;
        req = 4'b0; clr_ovf = 1'b0;
        got = sbq.pop_front();
        chk({nm, ".valid"}, row, {3'b0, out_valid}, {3'b0, got.valid});
        chk({nm, ".idx"}, row, {2'b0, out_idx}, {2'b0, got.idx});
        chk({nm, ".onehot"}, row, out_onehot, got.oh);
        chk({nm, ".pending"}, row, pending, got.pend);
        chk({nm, ".ovf"}, row, ovf, got.ovf);
    endtask

    initial begin
        // burst after reset
        vecs[0]  = mk(4'b1111, 1, 0, 1, 2'd0, 4'b0001, 4'b1110, 4'b0000);
        vecs[1]  = mk(4'b0000, 1, 0, 1, 2'd1, 4'b0010, 4'b1100, 4'b0000);
        vecs[2]  = mk(4'b0000, 1, 0, 1, 2'd2, 4'b0100, 4'b1000, 4'b0000);
        vecs[3]  = mk(4'b0000, 1, 0, 1, 2'd3, 4'b1000, 4'b0000, 4'b0000);
        vecs[4]  = mk(4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0000, 4'b0000);
        // stall
        vecs[5]  = mk(4'b0100, 0, 0, 1, 2'd2, 4'b0100, 4'b0000, 4'b0000);
        vecs[6]  = mk(4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b0001, 0, 0, 1, 2'd2, 4'b0100, 4'b0001, 4'b0000);
        vecs[8]  = mk(4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0001, 4'b0000);
        vecs[9]  = mk(4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0001, 4'b0000);
        vecs[10] = mk(4'b0000, 1, 0, 1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        vecs[11] = mk(4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
        // coalesce and ovf clear
        vecs[12] = mk(4'b1000, 0, 0, 1, 2'd3, 4'b1000, 4'b0000, 4'b0000);
        vecs[13] = mk(4'b1000, 0, 0, 1, 2'd3, 4'b1000, 4'b1000, 4'b0000);
        vecs[14] = mk(4'b1000, 0, 0, 1, 2'd3, 4'b1000, 4'b1000, 4'b1000);
        vecs[15] = mk(4'b0000, 0, 1, 1, 2'd3, 4'b1000, 4'b1000, 4'b0000);
        vecs[16] = mk(4'b0000, 1, 0, 1, 2'd3, 4'b1000, 4'b0000, 4'b0000);
        vecs[17] = mk(4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0000, 4'b0000);
        // same-cycle consume
        vecs[18] = mk(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 4'b0000, 4'b0000);
        vecs[19] = mk(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 4'b0000, 4'b0000);
        vecs[20] = mk(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 4'b0000, 4'b0000);
        vecs[21] = mk(4'b0000, 1, 0, 0, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        // coalesce and clear in the same cycle: set wins
        vecs[22] = mk(4'b0001, 0, 0, 1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        vecs[23] = mk(4'b0001, 0, 0, 1, 2'd0, 4'b0001, 4'b0001, 4'b0000);
        vecs[24] = mk(4'b0001, 0, 1, 1, 2'd0, 4'b0001, 4'b0001, 4'b0001);
        vecs[25] = mk(4'b0000, 1, 1, 1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        vecs[26] = mk(4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000);

        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 0, {3'b0, out_valid}, 4'b0);
        chk("rst.idx", 0, {2'b0, out_idx}, 4'b0);
        chk("rst.onehot", 0, out_onehot, 4'b0);
        chk("rst.pending", 0, pending, 4'b0);
        chk("rst.ovf", 0, ovf, 4'b0);
        rst_n = 1'b1;
        req = 4'b0;

        for (int i = 0; i < 27; i++)
            step(vecs[i].req, vecs[i].rdy, vecs[i].clr, 1'b1, vecs[i].e, "vec", i);

        // async reset with a held event and pending=1010
        step(4'b1011, 1'b0, 1'b0, 1'b1, '{1'b1, 2'd0, 4'b0001, 4'b1010, 4'b0000}, "prearst", 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 0, {3'b0, out_valid}, 4'b0);
        chk("arst.onehot", 0, out_onehot, 4'b0);
        chk("arst.pending", 0, pending, 4'b0);
        chk("arst.ovf", 0, ovf, 4'b0);
        chk("arst.idx", 0, {2'b0, out_idx}, 4'b0);
        #2;
        rst_n = 1'b1;
        m = '0;
        for (int i = 0; i < 2; i++) step(4'b0, 1'b1, 1'b0, 1'b0, '0, "postrst", i);

        injected = 0; lost = 0; m_acc = 0; dut_acc = 0;
        for (int i = 0; i < 10000; i++) begin
            logic [3:0] r;
            logic rd;
            logic c;
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            rd = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(r, rd, c, 1'b0, '0, "rand", i);
            chk("invariant", i, out_onehot, out_valid ? (4'b0001 << out_idx) : 4'b0000);
        end
        chk("accepted", 0, 4'(dut_acc - m_acc), 4'b0);
        checks++;
        if (injected != dut_acc + lost + $countones(pending) + int'(out_valid)) begin
            errors++;
            $display("FAIL conservation: got %0d accepted+%0d lost+%0d held, expected %0d injected",
                     dut_acc, lost, $countones(pending) + int'(out_valid), injected);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
